// File: rtl/lrshift_pkg.sv
// Shared constants for the lrshift family: FSM encodings, shift direction
// codes and default widths.
package lrshift_pkg;

  localparam int WIDTH_DEFAULT = 4;
  localparam int CNT_W_DEFAULT = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/lrshift_feeder_if.sv
// Bundle of the upstream word handshake and the serial drive toward
// lrshifter. master = stimulus/control side, slave = the feeder.
interface lrshift_feeder_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_dir;
  logic [CNT_W-1:0] in_len;
  logic             load;
  logic             d;
  logic             direction;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, in_data, in_dir, in_len,
    input  in_ready, load, d, direction, busy, done
  );

  modport slave (
    input  in_valid, in_data, in_dir, in_len,
    output in_ready, load, d, direction, busy, done
  );
endinterface

// File: rtl/lrshift_feeder.sv
// Serializes a parallel word into lrshifter's load/d/direction inputs,
// one bit per clock, so that the shifter holds the word after the last bit.
module lrshift_feeder
  import lrshift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  lrshift_feeder_if.slave  bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             load_q, load_d;
  logic             bit_q, bit_d;
  logic             direction_q, direction_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] eff_len;

  // Bit k of the transmit order: left sends MSB of the L-bit field first,
  // right sends bit 0 first.
  function automatic logic pick_bit(input logic [WIDTH-1:0] data,
                                    input logic             dir,
                                    input logic [CNT_W-1:0] len,
                                    input logic [CNT_W-1:0] k);
    logic [CNT_W-1:0] idx;
    logic             b;
    idx = (dir == DIR_RIGHT) ? k : (len - CNT_W'(1) - k);
    b = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (idx == CNT_W'(i)) b = data[i];
    end
    return b;
  endfunction

  // Effective length: 0 or anything above WIDTH saturates to WIDTH.
  always_comb begin
    eff_len = bus.in_len;
    if (bus.in_len == '0 || bus.in_len > CNT_W'(WIDTH)) eff_len = CNT_W'(WIDTH);
  end

  // Next-state logic: accept in IDLE, stream L bits in SHIFT, pulse done once.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    dir_d       = dir_q;
    len_d       = len_q;
    load_d      = load_q;
    bit_d       = bit_q;
    direction_d = direction_q;
    busy_d      = busy_q;
    done_d      = done_q;
    ready_d     = ready_q;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        load_d  = 1'b0;
        if (bus.in_valid && ready_q) begin
          data_d      = bus.in_data;
          dir_d       = bus.in_dir;
          len_d       = eff_len;
          cnt_d       = CNT_W'(1);
          state_d     = ST_SHIFT;
          ready_d     = 1'b0;
          busy_d      = 1'b1;
          load_d      = 1'b1;
          direction_d = bus.in_dir;
          bit_d       = pick_bit(bus.in_data, bus.in_dir, eff_len, '0);
        end
      end
      ST_SHIFT: begin
        if (cnt_q == len_q) begin
          load_d  = 1'b0;
          bit_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          bit_d = pick_bit(data_q, dir_q, len_q, cnt_q);
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        load_d  = 1'b0;
        bit_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any word in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      dir_q       <= DIR_LEFT;
      len_q       <= '0;
      load_q      <= 1'b0;
      bit_q       <= 1'b0;
      direction_q <= DIR_LEFT;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      dir_q       <= dir_d;
      len_q       <= len_d;
      load_q      <= load_d;
      bit_q       <= bit_d;
      direction_q <= direction_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.load      = load_q;
  assign bus.d         = bit_q;
  assign bus.direction = direction_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_lrshift_feeder.sv
// Directed bench for lrshift_feeder with a small lrshifter model downstream.
module tb_lrshift_feeder;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [3:0] sr;

  lrshift_feeder_if #(.WIDTH(4), .CNT_W(3)) bus ();

  lrshift_feeder #(.WIDTH(4), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference 4-bit bidirectional shifter fed by the DUT outputs.
  always @(posedge clk or posedge reset) begin
    if (reset) sr <= 4'b0;
    else if (bus.load) sr <= bus.direction ? {bus.d, sr[3:1]} : {sr[2:0], bus.d};
  end

  // Waits (bounded) for in_ready, then presents a word for exactly one accept edge.
  task automatic send_word(input logic [3:0] data, input logic dir, input logic [2:0] len);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: in_ready=%b required 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_dir   = dir;
    bus.in_len   = len;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.load, bus.d, bus.direction, bus.busy, bus.done, bus.in_ready} !== 6'b0) begin
        errors++;
        $display("FAIL reset_outputs: got %b required 000000",
                 {bus.load, bus.d, bus.direction, bus.busy, bus.done, bus.in_ready});
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: in_ready=%b required 0", bus.in_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_release: in_ready=%b busy=%b required 1 0", bus.in_ready, bus.busy);
    end
    $display("reset: released, in_ready=%b", bus.in_ready);
  endtask

  task automatic test_left_full;
    logic e [4];
    e = '{1'b1, 1'b0, 1'b1, 1'b1};
    send_word(4'b1011, 1'b0, 3'd0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.load !== 1'b1 || bus.d !== e[k] || bus.direction !== 1'b0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL left_bit%0d: load=%b d=%b dir=%b busy=%b required 1 %b 0 1",
                 k, bus.load, bus.d, bus.direction, bus.busy, e[k]);
      end
      @(negedge clk);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.load !== 1'b0 || bus.d !== 1'b0 || bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL left_done: done=%b load=%b d=%b busy=%b rdy=%b required 1 0 0 1 0",
               bus.done, bus.load, bus.d, bus.busy, bus.in_ready);
    end
    checks++;
    if (sr !== 4'b1011) begin
      errors++;
      $display("FAIL left_shifter: out=%b required 1011", sr);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.direction !== 1'b0) begin
      errors++;
      $display("FAIL left_idle: done=%b busy=%b rdy=%b dir=%b required 0 0 1 0",
               bus.done, bus.busy, bus.in_ready, bus.direction);
    end
    $display("left_full: word 1011 shifter=%b", sr);
  endtask

  task automatic test_right_full;
    logic e [4];
    e = '{1'b1, 1'b1, 1'b0, 1'b1};
    send_word(4'b1011, 1'b1, 3'd4);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.load !== 1'b1 || bus.d !== e[k] || bus.direction !== 1'b1) begin
        errors++;
        $display("FAIL right_bit%0d: load=%b d=%b dir=%b required 1 %b 1",
                 k, bus.load, bus.d, bus.direction, e[k]);
      end
      @(negedge clk);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.load !== 1'b0 || sr !== 4'b1011) begin
      errors++;
      $display("FAIL right_done: done=%b load=%b out=%b required 1 0 1011", bus.done, bus.load, sr);
    end
    @(negedge clk);
    checks++;
    if (bus.direction !== 1'b1 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL right_dir_hold: dir=%b rdy=%b required 1 1", bus.direction, bus.in_ready);
    end
    $display("right_full: word 1011 shifter=%b", sr);
  endtask

  task automatic test_partial;
    logic e [2];
    e = '{1'b1, 1'b0};
    send_word(4'b0110, 1'b0, 3'd2);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (bus.load !== 1'b1 || bus.d !== e[k]) begin
        errors++;
        $display("FAIL partial_bit%0d: load=%b d=%b required 1 %b", k, bus.load, bus.d, e[k]);
      end
      @(negedge clk);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.load !== 1'b0) begin
      errors++;
      $display("FAIL partial_done: done=%b load=%b required 1 0", bus.done, bus.load);
    end
    @(negedge clk);
    $display("partial: word 0110 len 2 done seen");
  endtask

  task automatic test_len_saturate;
    logic e [4];
    e = '{1'b1, 1'b0, 1'b1, 1'b1};
    send_word(4'b1011, 1'b0, 3'd7);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.load !== 1'b1 || bus.d !== e[k]) begin
        errors++;
        $display("FAIL sat_bit%0d: load=%b d=%b required 1 %b", k, bus.load, bus.d, e[k]);
      end
      @(negedge clk);
    end
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL sat_done: done=%b required 1", bus.done);
    end
    @(negedge clk);
    $display("len_saturate: len 7 sent as 4 bits");
  endtask

  task automatic test_back_to_back;
    logic e1 [4];
    logic e2 [4];
    int   gap;
    e1 = '{1'b1, 1'b1, 1'b0, 1'b0};
    e2 = '{1'b0, 1'b0, 1'b1, 1'b1};
    bus.in_valid = 1'b1;
    bus.in_data  = 4'b1100;
    bus.in_dir   = 1'b0;
    bus.in_len   = 3'd0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.load !== 1'b1 || bus.d !== e1[k] || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_w1_bit%0d: load=%b d=%b rdy=%b required 1 %b 0",
                 k, bus.load, bus.d, bus.in_ready, e1[k]);
      end
      if (k == 0) bus.in_data = 4'b0011;
      @(negedge clk);
    end
    gap = 4;
    while (bus.load !== 1'b1 && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    checks++;
    if (gap !== 6) begin
      errors++;
      $display("FAIL b2b_period: period=%0d required 6", gap);
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.load !== 1'b1 || bus.d !== e2[k]) begin
        errors++;
        $display("FAIL b2b_w2_bit%0d: load=%b d=%b required 1 %b", k, bus.load, bus.d, e2[k]);
      end
      @(negedge clk);
    end
    checks++;
    if (bus.done !== 1'b1 || sr !== 4'b0011) begin
      errors++;
      $display("FAIL b2b_done: done=%b out=%b required 1 0011", bus.done, sr);
    end
    @(negedge clk);
    $display("back_to_back: period=%0d shifter=%b", gap, sr);
  endtask

  task automatic test_reset_mid;
    logic e [3];
    e = '{1'b1, 1'b0, 1'b1};
    send_word(4'b1111, 1'b0, 3'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.load !== 1'b0 || bus.d !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: load=%b d=%b busy=%b rdy=%b required 0 0 0 0",
               bus.load, bus.d, bus.busy, bus.in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_done: done=%b required 0", bus.done);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    send_word(4'b0101, 1'b1, 3'd3);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.load !== 1'b1 || bus.d !== e[k] || bus.direction !== 1'b1) begin
        errors++;
        $display("FAIL post_abort_bit%0d: load=%b d=%b dir=%b required 1 %b 1",
                 k, bus.load, bus.d, bus.direction, e[k]);
      end
      @(negedge clk);
    end
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL post_abort_done: done=%b required 1", bus.done);
    end
    @(negedge clk);
    $display("reset_mid: aborted 1111, then sent 0101 right len 3");
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 4'b0;
    bus.in_dir   = 1'b0;
    bus.in_len   = 3'd0;
    test_reset();
    test_left_full();
    test_right_full();
    test_partial();
    test_len_saturate();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lrshift_feeder.md
Name: lrshift_feeder

Overview:
Upstream serializer for the bidirectional 4-bit shift register (lrshifter). Accepts a parallel word plus direction over a valid/ready handshake. Drives the shifter's load, d and direction inputs one bit per clock, so that after the last bit the shifter holds the word. Sits between the control/stimulus logic and lrshifter; outputs connect 1:1 to lrshifter's load/d/direction.

Parameters:
WIDTH, 4, word width; matches lrshifter width
CNT_W, 3, bit-counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  upstream word valid
in_ready  output  1  feeder can accept a word this cycle
in_data  input  WIDTH  word to serialize
in_dir  input  1  0 = left shift (MSB first), 1 = right shift (LSB first)
in_len  input  CNT_W  number of bits to send, 1..WIDTH; 0 means WIDTH
load  output  1  shift-enable to lrshifter
d  output  1  serial data bit to lrshifter
direction  output  1  shift direction to lrshifter
busy  output  1  high from accept until done
done  output  1  one-cycle pulse after the final bit

Behaviour:
- One clock (clk); reset is asynchronous and active-high. All state and outputs are registered.
- Reset values: state=IDLE, load=0, d=0, direction=0, busy=0, done=0, in_ready=0. in_ready rises on the first clk edge after reset deasserts.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1, load=0.
  - Accept on a clk edge with in_valid && in_ready. Latch in_data, in_dir and effective length L (in_len==0 or in_len>WIDTH -> WIDTH).
  - At the same edge: in_ready->0, busy->1, state->SHIFT, load->1, direction->in_dir, d->first bit.
- SHIFT: load=1 and direction held constant for exactly L cycles.
  - Left: bit order in_data[L-1], in_data[L-2] ... in_data[0].
  - Right: bit order in_data[0], in_data[1] ... in_data[L-1].
  - Counter runs 0..L-1; d updates every edge.
  - On the edge after bit L-1: load->0, d->0, done->1, state->DONE.
- DONE: exactly one cycle. done=1, busy=1, in_ready=0. Next edge: done->0, busy->0, in_ready->1, state->IDLE.
- Timing: accept-to-done latency is L+1 edges. Minimum word period is L+2 cycles. A back-to-back in_valid is accepted only in IDLE.
- in_valid while not in IDLE is ignored; the upstream must hold the word until in_ready.
- in_data, in_dir and in_len changing during SHIFT have no effect (values latched at accept).
- direction keeps its last value in IDLE/DONE; only load gates the shifter.
- Reset mid-SHIFT or mid-DONE aborts immediately (asynchronous). The word is discarded with no done pulse, and all outputs take their reset values.
- in_len width: values above WIDTH are treated as WIDTH (saturate, no wrap).

Decomposition:
- Shared package/include lrshift_pkg:
  - state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2)
  - DIR_LEFT=1'b0, DIR_RIGHT=1'b1
  - default WIDTH=4
- lrshifter imports the same DIR constants.
- No sub-module; a single FSM plus counter and bit-select mux.

Test Plan:
- Reset: hold reset 2 cycles, then release -> all outputs 0 during reset; in_ready=1 one edge after release.
- Left, full word: in_data=4'b1011, in_dir=0, in_len=0 -> d sequence 1,0,1,1 with load=1 for 4 cycles, direction=0; done pulses on edge 5; downstream lrshifter out=1011.
- Right, full word: in_data=4'b1011, in_dir=1, in_len=4 -> d sequence 1,1,0,1, direction=1 for 4 cycles; downstream out=1011.
- Partial length: in_data=4'b0110, in_dir=0, in_len=2 -> d sequence 1,0; load high exactly 2 cycles; done on edge 3.
- Back-to-back with ignored valid: hold in_valid=1 continuously with 4'b1100 then 4'b0011 -> second accept occurs only after DONE (6-cycle period); in_data change mid-SHIFT does not alter d.
- Reset mid-operation: assert reset after the 2nd bit of 4'b1111 -> load, d, busy immediately 0; no done pulse; the next word after release serializes correctly.
